// File: rtl/mem_island_pkg.sv
// Shared types and helpers for the memory island (burst splitter, bank splitter).
// Address alignment is kept here so every block rounds addresses identically.
package mem_island_pkg;

   localparam int unsigned DefaultLenWidth = 8;

   typedef logic [DefaultLenWidth-1:0] len_t;

   typedef enum logic {
      ST_IDLE,
      ST_ISSUE
   } burst_state_e;

   // Clears the byte-offset bits below one beat; beat_bytes must be a power of two.
   function automatic logic [63:0] align_addr(input logic [63:0] addr,
                                              input int unsigned beat_bytes);
      return addr & ~(64'(beat_bytes) - 64'd1);
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with the common_cells fifo_v3 port shape.
// A push while full is accepted when a pop happens in the same cycle.
module fifo_v3 #(
   parameter bit          FALL_THROUGH = 1'b0,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_DEPTH-1:0] usage_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic                  do_push, do_pop;

   function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
      return (ptr == ADDR_DEPTH'(DEPTH - 1)) ? '0 : ptr + ADDR_DEPTH'(1);
   endfunction

   assign full_o  = (cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q[ADDR_DEPTH-1:0];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      data_o   = mem_q[rd_ptr_q];
      do_push  = push_i && (!full_o || pop_i);
      do_pop   = pop_i && !empty_o;
      if (FALL_THROUGH && empty_o && push_i) begin
         data_o = data_i;
         if (pop_i) begin
            do_push = 1'b0;
            do_pop  = 1'b0;
         end
      end
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + (ADDR_DEPTH + 1)'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - (ADDR_DEPTH + 1)'(1);
      end
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         mem_q    <= '{default: '0};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/mem_burst_splitter.sv
// Breaks one incrementing burst into single-beat memory requests, bounding beats
// in flight and tagging each in-order response with the burst's last flag.
module mem_burst_splitter
   import mem_island_pkg::*;
#(
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned DataWidth  = 64,
   parameter int unsigned WUserWidth = 1,
   parameter int unsigned RUserWidth = 1,
   parameter int unsigned LenWidth   = 8,
   parameter int unsigned MaxTrans   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   burst_req_i,
   output logic                   burst_gnt_o,
   input  logic [AddrWidth-1:0]   burst_addr_i,
   input  logic [LenWidth-1:0]    burst_len_i,
   input  logic                   burst_we_i,
   input  logic [WUserWidth-1:0]  burst_wuser_i,
   input  logic                   wvalid_i,
   output logic                   wready_o,
   input  logic [DataWidth-1:0]   wdata_i,
   input  logic [DataWidth/8-1:0] wstrb_i,
   output logic                   mem_req_o,
   input  logic                   mem_gnt_i,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   output logic [DataWidth/8-1:0] mem_strb_o,
   output logic [WUserWidth-1:0]  mem_wuser_o,
   output logic                   mem_we_o,
   input  logic                   mem_rvalid_i,
   output logic                   mem_rready_o,
   input  logic [DataWidth-1:0]   mem_rdata_i,
   input  logic [RUserWidth-1:0]  mem_ruser_i,
   output logic                   rvalid_o,
   input  logic                   rready_i,
   output logic [DataWidth-1:0]   rdata_o,
   output logic [RUserWidth-1:0]  ruser_o,
   output logic                   rlast_o
);

   localparam int unsigned BeatBytes = DataWidth / 8;
   localparam int unsigned UsageW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

   burst_state_e          state_q, state_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [LenWidth-1:0]   remaining_q, remaining_d;
   logic                  we_q, we_d;
   logic [WUserWidth-1:0] wuser_q, wuser_d;

   logic              fifo_full, fifo_empty, fifo_head, fifo_pop;
   logic [UsageW-1:0] fifo_usage;
   logic [UsageW:0]   outstanding;
   logic              can_issue, req_ok, beat_fire;

   // A response popped this cycle frees a slot for a request in the same cycle.
   assign fifo_pop    = mem_rvalid_i && rready_i;
   assign outstanding = fifo_full ? (UsageW + 1)'(MaxTrans) : {1'b0, fifo_usage};
   assign can_issue   = (outstanding - {{UsageW{1'b0}}, fifo_pop}) < (UsageW + 1)'(MaxTrans);
   assign req_ok      = (state_q == ST_ISSUE) && can_issue && (!we_q || wvalid_i);
   assign beat_fire   = req_ok && mem_gnt_i;

   assign mem_req_o   = req_ok;
   assign wready_o    = we_q && beat_fire;
   assign mem_addr_o  = addr_q;
   assign mem_we_o    = we_q;
   assign mem_wuser_o = wuser_q;
   assign mem_wdata_o = wdata_i;
   assign mem_strb_o  = we_q ? wstrb_i : '1;

   assign rvalid_o     = mem_rvalid_i;
   assign mem_rready_o = rready_i;
   assign rdata_o      = mem_rdata_i;
   assign ruser_o      = mem_ruser_i;
   assign rlast_o      = !fifo_empty && fifo_head;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      we_d        = we_q;
      wuser_d     = wuser_q;
      burst_gnt_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            burst_gnt_o = 1'b1;
            if (burst_req_i) begin
               addr_d      = AddrWidth'(align_addr(64'(burst_addr_i), BeatBytes));
               remaining_d = burst_len_i;
               we_d        = burst_we_i;
               wuser_d     = burst_wuser_i;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (beat_fire) begin
               addr_d      = addr_q + AddrWidth'(BeatBytes);
               remaining_d = remaining_q - LenWidth'(1);
               if (remaining_q == '0) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         we_q        <= 1'b0;
         wuser_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         we_q        <= we_d;
         wuser_q     <= wuser_d;
      end
   end

   fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (1),
      .DEPTH        (MaxTrans)
   ) i_last_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (fifo_usage),
      .data_i  (remaining_q == '0),
      .push_i  (beat_fire),
      .data_o  (fifo_head),
      .pop_i   (fifo_pop)
   );

   // A write beat, once offered, must keep its data valid until granted.
   a_wvalid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mem_req_o && !mem_gnt_i && we_q) |=> wvalid_i);

   a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
      mem_rvalid_i |-> !fifo_empty);

endmodule
